apb_reg_responder: RTL and testbench

//  APB completer (responder) for the register-map end of the crypto-accelerator APB path.

---
 rtl/crypto_apb_pkg.sv | 37 +++
 rtl/apb_reg_decode.sv | 38 +++
 rtl/apb_reg_responder.sv | 200 ++++++++++++++++++++
 tb/tb_apb_reg_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_apb_pkg.sv
// Shared definitions for the crypto-accelerator APB register path:
// bus widths, responder FSM encoding and fixed register indices.
package crypto_apb_pkg;

  localparam int APB_DATA_W   = 16;
  localparam int APB_ADDR_W   = 20;
  localparam int APB_STRB_W   = 2;
  localparam int WAIT_CNT_W   = 4;

  localparam int ID_IDX       = 0;
  localparam int STATUS_IDX   = 1;
  localparam int FIRST_RW_IDX = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } apbState_e;

  // Merge new write data into an old register value, byte lane by byte lane
  function automatic logic [APB_DATA_W-1:0] applyStrobe(
    input logic [APB_DATA_W-1:0] oldVal,
    input logic [APB_DATA_W-1:0] newVal,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] res;
    res = oldVal;
    for (int b = 0; b < APB_STRB_W; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = newVal[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// Address decoder for the APB register responder: turns a byte address
// into a register index and flags every access that must be refused.
module apb_reg_decode
  import crypto_apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 20'h00000,
  parameter int                    NUM_REGS  = 8,
  parameter int                    IDX_W     = 3
) (
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [APB_STRB_W-1:0] pstrb_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  err_o
);

  logic [APB_ADDR_W-1:0] offset;
  logic [APB_ADDR_W-1:0] idxWide;
  logic                  belowBase;
  logic                  outOfRange;
  logic                  misaligned;
  logic                  roWrite;
  logic                  noStrobe;

  // Full-width index so addresses far above the map cannot alias onto a register
  always_comb begin
    offset     = paddr_i - BASE_ADDR;
    idxWide    = offset >> 1;
    belowBase  = (paddr_i < BASE_ADDR);
    outOfRange = (idxWide >= APB_ADDR_W'(NUM_REGS));
    misaligned = paddr_i[0];
    roWrite    = pwrite_i && (idxWide < APB_ADDR_W'(FIRST_RW_IDX));
    noStrobe   = pwrite_i && (pstrb_i == '0);
    err_o      = belowBase || outOfRange || misaligned || roWrite || noStrobe;
    idx_o      = idxWide[IDX_W-1:0];
  end

endmodule

// File: rtl/apb_reg_responder.sv
// APB completer for the crypto-accelerator register map. Holds the ID and
// live-status registers plus a bank of RW configuration registers exported
// to the datapath, with a programmable number of wait states per transfer.
module apb_reg_responder
  import crypto_apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 20'h00000,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 16'hC0DE,
  parameter logic [APB_DATA_W-1:0] RESET_VAL   = 16'h0000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               psel,
  input  logic                               penable,
  input  logic                               pwrite,
  input  logic [APB_STRB_W-1:0]              pstrb,
  input  logic [APB_ADDR_W-1:0]              paddr,
  input  logic [APB_DATA_W-1:0]              pwdata,
  input  logic [APB_DATA_W-1:0]              status_in,
  output logic [APB_DATA_W-1:0]              prdata,
  output logic                               pready,
  output logic                               pslverr,
  output logic [APB_DATA_W*(NUM_REGS-2)-1:0] cfg_o
);

  localparam int NUM_RW = NUM_REGS - FIRST_RW_IDX;
  localparam int IDX_W  = $clog2(NUM_REGS);

  apbState_e               state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    capture;
  logic                    respNext;

  logic                    wr_q;
  logic [APB_STRB_W-1:0]   strb_q;
  logic [APB_ADDR_W-1:0]   addr_q;
  logic [APB_DATA_W-1:0]   wdata_q;

  logic                    curWrite;
  logic [APB_STRB_W-1:0]   curStrb;
  logic [APB_ADDR_W-1:0]   curAddr;
  logic [APB_DATA_W-1:0]   curWdata;

  logic [IDX_W-1:0]        decIdx;
  logic                    decErr;
  logic [APB_DATA_W-1:0]   readData;

  logic [APB_DATA_W-1:0]   rwRegs_q [NUM_RW];
  logic [APB_DATA_W-1:0]   status_q;
  logic [APB_DATA_W-1:0]   prdata_q;
  logic                    pready_q;
  logic                    pslverr_q;

  // In IDLE the request is still on the bus (zero-wait responses use it directly);
  // afterwards the copy captured at access-phase detect is used
  always_comb begin
    curWrite = (state_q == ST_IDLE) ? pwrite : wr_q;
    curStrb  = (state_q == ST_IDLE) ? pstrb  : strb_q;
    curAddr  = (state_q == ST_IDLE) ? paddr  : addr_q;
    curWdata = (state_q == ST_IDLE) ? pwdata : wdata_q;
  end

  apb_reg_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_decode (
    .paddr_i  (curAddr),
    .pwrite_i (curWrite),
    .pstrb_i  (curStrb),
    .idx_o    (decIdx),
    .err_o    (decErr)
  );

  // Next-state logic; DONE holds until the requester drops its access phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (psel && penable) begin
          capture = 1'b1;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!psel || !penable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!psel || !penable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    respNext = (state_d == ST_RESP);
  end

  // State register and request capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wr_q    <= pwrite;
        strb_q  <= pstrb;
        addr_q  <= paddr;
        wdata_q <= pwdata;
      end
    end
  end

  // Read mux over ID constant, sampled status and the RW bank
  always_comb begin
    readData = '0;
    if (decIdx == IDX_W'(ID_IDX)) begin
      readData = ID_VALUE;
    end else if (decIdx == IDX_W'(STATUS_IDX)) begin
      readData = status_q;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (decIdx == IDX_W'(i + FIRST_RW_IDX)) begin
          readData = rwRegs_q[i];
        end
      end
    end
  end

  // Response outputs are loaded on the edge that enters RESP, so they last one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= respNext;
      pslverr_q <= respNext && decErr;
      prdata_q  <= (respNext && !decErr && !curWrite) ? readData : '0;
    end
  end

  // RW bank: a write lands together with its response; refused writes change nothing
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RW; i++) begin
        rwRegs_q[i] <= RESET_VAL;
      end
    end else if (respNext && curWrite && !decErr) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (decIdx == IDX_W'(i + FIRST_RW_IDX)) begin
          rwRegs_q[i] <= applyStrobe(rwRegs_q[i], curWdata, curStrb);
        end
      end
    end
  end

  // Live status is resampled every cycle so reads see last cycle's value
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= status_in;
    end
  end

  // Pack the RW bank for the datapath, lowest RW register in the LSBs
  always_comb begin
    cfg_o = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      cfg_o[i*APB_DATA_W +: APB_DATA_W] = rwRegs_q[i];
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_responder.sv
// Directed bench for apb_reg_responder. Three copies share one APB stimulus:
// unit 0 has no wait states, unit 1 one, unit 2 three; each step checks one unit.
module tb_apb_reg_responder;

  logic        clk;
  logic        reset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [1:0]  pstrb;
  logic [19:0] paddr;
  logic [15:0] pwdata;
  logic [15:0] status_in;

  logic [15:0] prdata_w  [3];
  logic        pready_w  [3];
  logic        pslverr_w [3];
  logic [95:0] cfg_w     [3];

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] rd;
  logic        er;
  logic        sawPulse;

  apb_reg_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .status_in(status_in),
    .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]), .cfg_o(cfg_w[0])
  );

  apb_reg_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .status_in(status_in),
    .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]), .cfg_o(cfg_w[1])
  );

  apb_reg_responder #(.WAIT_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .status_in(status_in),
    .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]), .cfg_o(cfg_w[2])
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int waitOf(input int unit);
    return (unit == 2) ? 3 : unit;
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full APB transfer; n counts cycles from the access-phase cycle (n=0)
  task automatic applyStimulus(input int unit, input logic wr, input logic [1:0] strb,
                               input logic [19:0] addr, input logic [15:0] wdata,
                               input int hold, input string tag,
                               output logic [15:0] rdata, output logic err);
    int  lat;
    bit  seen;
    @(posedge clk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    pstrb   = strb;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    seen  = 1'b0;
    lat   = -1;
    rdata = 16'hxxxx;
    err   = 1'bx;
    for (int n = 0; n < 24 && !seen; n++) begin
      @(negedge clk);
      if (pready_w[unit]) begin
        seen  = 1'b1;
        lat   = n;
        rdata = prdata_w[unit];
        err   = pslverr_w[unit];
      end
    end
    checkOutput({tag, "_latency"}, 96'(lat), 96'(1 + waitOf(unit)));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, "_nopulse"}, 96'(pready_w[unit]), 96'(0));
      checkOutput({tag, "_prdata0"}, 96'(prdata_w[unit]), 96'(0));
    end
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    pstrb     = 2'b00;
    paddr     = 20'h0;
    pwdata    = 16'h0;
    status_in = 16'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pready",  96'(pready_w[1]),  96'(0));
    checkOutput("rst_prdata",  96'(prdata_w[1]),  96'(0));
    checkOutput("rst_pslverr", 96'(pslverr_w[1]), 96'(0));
    checkOutput("rst_cfg",     cfg_w[1],          96'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // ID register read with one wait state
    applyStimulus(1, 1'b0, 2'b00, 20'h00000, 16'h0, 0, "t1_id", rd, er);
    checkOutput("t1_prdata",  96'(rd), 96'(16'hC0DE));
    checkOutput("t1_pslverr", 96'(er), 96'(0));

    // Full write followed by a low-byte-only write
    applyStimulus(1, 1'b1, 2'b11, 20'h00004, 16'hA5A5, 0, "t2_wr1", rd, er);
    checkOutput("t2_wr1_err", 96'(er), 96'(0));
    applyStimulus(1, 1'b1, 2'b01, 20'h00004, 16'h1234, 0, "t2_wr2", rd, er);
    checkOutput("t2_wr2_err", 96'(er), 96'(0));
    applyStimulus(1, 1'b0, 2'b00, 20'h00004, 16'h0, 0, "t2_rd", rd, er);
    checkOutput("t2_rd_data", 96'(rd), 96'(16'hA534));
    checkOutput("t2_cfg",     96'(cfg_w[1][15:0]), 96'(16'hA534));

    // Refused accesses
    applyStimulus(1, 1'b1, 2'b11, 20'h00000, 16'hFFFF, 0, "t3_wr_id", rd, er);
    checkOutput("t3_wr_id_err",  96'(er), 96'(1));
    checkOutput("t3_wr_id_data", 96'(rd), 96'(0));
    applyStimulus(1, 1'b0, 2'b00, 20'h00010, 16'h0, 0, "t3_oor", rd, er);
    checkOutput("t3_oor_err",  96'(er), 96'(1));
    checkOutput("t3_oor_data", 96'(rd), 96'(0));
    applyStimulus(1, 1'b0, 2'b00, 20'h00001, 16'h0, 0, "t3_odd", rd, er);
    checkOutput("t3_odd_err",  96'(er), 96'(1));
    checkOutput("t3_odd_data", 96'(rd), 96'(0));
    applyStimulus(1, 1'b1, 2'b00, 20'h00004, 16'hFFFF, 0, "t3_nostrb", rd, er);
    checkOutput("t3_nostrb_err",  96'(er), 96'(1));
    checkOutput("t3_nostrb_data", 96'(rd), 96'(0));
    checkOutput("t3_cfg_kept",    cfg_w[1], 96'(16'hA534));
    applyStimulus(1, 1'b0, 2'b00, 20'h00000, 16'h0, 0, "t3_id", rd, er);
    checkOutput("t3_id_data", 96'(rd), 96'(16'hC0DE));

    // Access phase held after completion: one pulse, then a normal transfer
    applyStimulus(1, 1'b0, 2'b00, 20'h00004, 16'h0, 3, "t4_hold", rd, er);
    checkOutput("t4_hold_data", 96'(rd), 96'(16'hA534));
    applyStimulus(1, 1'b0, 2'b00, 20'h00000, 16'h0, 0, "t4_next", rd, er);
    checkOutput("t4_next_data", 96'(rd), 96'(16'hC0DE));
    checkOutput("t4_next_err",  96'(er), 96'(0));

    // Three wait states: completed write, aborted write, reset mid-wait
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(2, 1'b1, 2'b11, 20'h00004, 16'h5A5A, 0, "t5_wr", rd, er);
    checkOutput("t5_wr_err", 96'(er), 96'(0));
    checkOutput("t5_wr_cfg", 96'(cfg_w[2][15:0]), 96'(16'h5A5A));

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pstrb = 2'b11;
    paddr = 20'h00004; pwdata = 16'hBEEF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    penable = 1'b0;
    sawPulse = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pready_w[2]) sawPulse = 1'b1;
    end
    checkOutput("t5_abort_pready", 96'(sawPulse), 96'(0));
    checkOutput("t5_abort_cfg",    96'(cfg_w[2][15:0]), 96'(16'h5A5A));
    @(posedge clk); #1;
    psel = 1'b0;

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pstrb = 2'b11;
    paddr = 20'h00006; pwdata = 16'h7777;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_rst_pready",  96'(pready_w[2]),  96'(0));
    checkOutput("t5_rst_prdata",  96'(prdata_w[2]),  96'(0));
    checkOutput("t5_rst_pslverr", 96'(pslverr_w[2]), 96'(0));
    checkOutput("t5_rst_cfg",     cfg_w[2],          96'(0));
    @(posedge clk); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    sawPulse = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready_w[2]) sawPulse = 1'b1;
    end
    checkOutput("t5_rst_nopready", 96'(sawPulse), 96'(0));

    // Live status read, then the zero-wait configuration
    status_in = 16'h00F1;
    applyStimulus(1, 1'b0, 2'b00, 20'h00002, 16'h0, 0, "t6_status", rd, er);
    checkOutput("t6_status_data", 96'(rd), 96'(16'h00F1));
    checkOutput("t6_status_err",  96'(er), 96'(0));
    applyStimulus(0, 1'b0, 2'b00, 20'h00000, 16'h0, 0, "t6_w0_id", rd, er);
    checkOutput("t6_w0_id_data", 96'(rd), 96'(16'hC0DE));
    applyStimulus(0, 1'b1, 2'b10, 20'h0000E, 16'hFFFF, 0, "t6_w0_wr", rd, er);
    checkOutput("t6_w0_wr_err", 96'(er), 96'(0));
    checkOutput("t6_w0_cfg",    96'(cfg_w[0][95:80]), 96'(16'hFF00));
    applyStimulus(0, 1'b0, 2'b00, 20'h0000E, 16'h0, 0, "t6_w0_rd", rd, er);
    checkOutput("t6_w0_rd_data", 96'(rd), 96'(16'hFF00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
